// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller (4-word lines).
// Define DCACHE_STATS_EN to add saturating hit/miss/writeback counters as outputs.
module dcache_ctrl #(
    parameter int IDX_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_re,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_rdy,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [13:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_rdy
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt,
    output logic [15:0] wb_cnt
`endif
);

    localparam int LINES    = 1 << IDX_BITS;
    localparam int TAG_BITS = 14 - IDX_BITS;

    typedef enum logic [1:0] {IDLE, WBACK, FILL} state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [63:0]         data_q [LINES];

    logic [IDX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] req_tag;
    logic [1:0]          word;
    logic                req;
    logic                hit;
    logic                victim_dirty;
    logic [63:0]         line;
    logic [15:0]         hit_word;
    logic                hit_done;
    logic                miss_start;
    logic                wb_done;
    logic                fill_done;

    assign idx          = cpu_addr[IDX_BITS+1:2];
    assign req_tag      = cpu_addr[15:IDX_BITS+2];
    assign word         = cpu_addr[1:0];
    assign req          = cpu_re | cpu_we;
    assign line         = data_q[idx];
    assign hit          = valid_q[idx] && (tag_q[idx] == req_tag);
    assign victim_dirty = valid_q[idx] & dirty_q[idx];
    assign hit_word     = line[{word, 4'b0000} +: 16];

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cpu_rdy    = 1'b0;
        cpu_rdata  = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        hit_done   = 1'b0;
        miss_start = 1'b0;
        wb_done    = 1'b0;
        fill_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        cpu_rdy  = 1'b1;
                        hit_done = 1'b1;
                        if (!cpu_we) cpu_rdata = hit_word;
                    end else begin
                        miss_start = 1'b1;
                        state_d    = victim_dirty ? WBACK : FILL;
                    end
                end
            end
            WBACK: begin
                mem_wr = 1'b1;
                if (mem_rdy) begin
                    wb_done = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                mem_rd = 1'b1;
                if (mem_rdy) begin
                    fill_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            dirty_q   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                if (victim_dirty) begin
                    mem_addr  <= {tag_q[idx], idx};
                    mem_wdata <= line;
                end else begin
                    mem_addr <= cpu_addr[15:2];
                end
            end
            if (hit_done && cpu_we) dirty_q[idx] <= 1'b1;
            if (wb_done) begin
                dirty_q[idx] <= 1'b0;
                mem_addr     <= cpu_addr[15:2];
            end
            if (fill_done) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

    // NOTE: tag/data arrays carry no reset; valid bits alone qualify them, and gating on rst
    // keeps a fill that completes under reset from landing in the array.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill_done) begin
                data_q[idx] <= mem_rdata;
                tag_q[idx]  <= req_tag;
            end else if (hit_done && cpu_we) begin
                data_q[idx][{word, 4'b0000} +: 16] <= cpu_wdata;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    // The completion right after a fill belongs to the miss, so it is not counted as a hit.
    logic post_fill_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            post_fill_q <= 1'b0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            wb_cnt      <= '0;
        end else begin
            post_fill_q <= fill_done;
            if (hit_done && !post_fill_q && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            if (miss_start && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            if (wb_done && wb_cnt != 16'hFFFF) wb_cnt <= wb_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed bench with a line-level cache model and a backing-memory responder.
// Checks latency, memory traffic, load data, protocol rules and reset behaviour.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_re, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_rdy, mem_rd, mem_wr;
    logic [13:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic        mem_rdy;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt, wb_cnt;
`endif

    dcache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_re    (cpu_re),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_rdy   (cpu_rdy),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt),
        .wb_cnt    (wb_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- backing memory responder ----------------
    typedef struct {
        bit          wr;
        logic [13:0] addr;
        logic [63:0] data;
    } ev_t;

    ev_t         ev_q[$];
    logic [63:0] bmem [int];
    int          rsp_delay = 3;
    int          rsp_cnt   = 0;

    function automatic logic [63:0] mem_line(input int la);
        if (bmem.exists(la)) return bmem[la];
        return {16'(la), 16'hC0DE, 16'(la) ^ 16'h5555, 16'hF00D};
    endfunction

    initial begin
        mem_rdy   = 1'b0;
        mem_rdata = '0;
    end

    always @(negedge clk) begin
        if (mem_rdy) rsp_cnt = 0;
        mem_rdy = 1'b0;
        if (mem_rd || mem_wr) begin
            rsp_cnt++;
            if (rsp_cnt >= rsp_delay) begin
                if (mem_wr) begin
                    bmem[int'(mem_addr)] = mem_wdata;
                    ev_q.push_back('{1'b1, mem_addr, mem_wdata});
                end else begin
                    mem_rdata = mem_line(int'(mem_addr));
                    ev_q.push_back('{1'b0, mem_addr, mem_rdata});
                end
                mem_rdy = 1'b1;
            end
        end else begin
            rsp_cnt = 0;
        end
    end

    // ---------------- per-cycle protocol monitor ----------------
    bit          mon_en = 1'b0;
    int          prev_op = 0;
    bit          prev_rdy = 1'b0;
    logic [13:0] prev_addr;
    logic [63:0] prev_wdata;

    always @(negedge clk) begin
        int op;
        #1;
        if (mon_en && !rst) begin
            check("rd_wr_overlap", {63'd0, mem_rd & mem_wr}, 64'd0);
            if (!cpu_re && !cpu_we) check("rdy_without_req", {63'd0, cpu_rdy}, 64'd0);
            op = mem_wr ? 2 : (mem_rd ? 1 : 0);
            if (op != 0 && op == prev_op && !prev_rdy) begin
                check("mem_addr_stable", {50'd0, mem_addr}, {50'd0, prev_addr});
                check("mem_wdata_stable", mem_wdata, prev_wdata);
            end
            prev_op    = op;
            prev_rdy   = mem_rdy;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
        end else begin
            prev_op = 0;
        end
    end

    // ---------------- line-level cache model ----------------
    bit          m_valid [8];
    bit          m_dirty [8];
    int          m_tag   [8];
    logic [63:0] m_line  [8];
    logic [15:0] last_rdata;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    // Presents one request and holds it until completion; leaves it driven so the next
    // call follows without a bubble.
    task automatic access(input logic [15:0] addr, input logic we, input logic re,
                          input logic [15:0] wd, input string name);
        int          a      = int'(addr);
        int          idx    = (a / 4) % 8;
        int          tg     = a / 32;
        int          w      = a % 4;
        int          la     = a / 4;
        bit          hit    = m_valid[idx] && (m_tag[idx] == tg);
        bit          wb     = !hit && m_valid[idx] && m_dirty[idx];
        int          exp_n  = hit ? 1 : (wb ? 2 * rsp_delay + 2 : rsp_delay + 2);
        int          exp_ev = hit ? 0 : (wb ? 2 : 1);
        logic [63:0] fill   = mem_line(la);
        logic [63:0] victim = m_line[idx];
        int          vla    = m_tag[idx] * 8 + idx;
        logic [63:0] cur;
        int          n      = 0;
        bit          done   = 1'b0;

        ev_q.delete();
        cpu_addr  = addr;
        cpu_we    = we;
        cpu_re    = re;
        cpu_wdata = wd;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (cpu_rdy === 1'b1) begin
                done       = 1'b1;
                last_rdata = cpu_rdata;
            end
        end
        if (!done) check({name, "_timeout"}, 64'd0, 64'd1);
        check({name, "_latency"}, 64'(n), 64'(exp_n));
        check({name, "_mem_ops"}, 64'(ev_q.size()), 64'(exp_ev));
        if (ev_q.size() == exp_ev && exp_ev > 0) begin
            if (wb) begin
                check({name, "_wb_is_write"}, {63'd0, ev_q[0].wr}, 64'd1);
                check({name, "_wb_addr"}, {50'd0, ev_q[0].addr}, 64'(vla));
                check({name, "_wb_data"}, ev_q[0].data, victim);
            end
            check({name, "_fill_is_read"}, {63'd0, ev_q[exp_ev-1].wr}, 64'd0);
            check({name, "_fill_addr"}, {50'd0, ev_q[exp_ev-1].addr}, 64'(la));
        end
        if (!hit) begin
            m_line[idx]  = fill;
            m_tag[idx]   = tg;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end
        cur = m_line[idx];
        if (re && !we) check({name, "_rdata"}, {48'd0, last_rdata}, {48'd0, cur[w*16 +: 16]});
        if (we) begin
            m_line[idx][w*16 +: 16] = wd;
            m_dirty[idx] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_re = 1'b0;
        cpu_we = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int start;
        int n;
        rst       = 1'b1;
        cpu_re    = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        model_reset();
        bmem[4] = {16'h0003, 16'h0002, 16'h0001, 16'hBEEF};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_cpu_rdy", {63'd0, cpu_rdy}, 64'd0);
        check("reset_mem_rd", {63'd0, mem_rd}, 64'd0);
        check("reset_mem_wr", {63'd0, mem_wr}, 64'd0);
        check("reset_mem_addr", {50'd0, mem_addr}, 64'd0);
        check("reset_mem_wdata", mem_wdata, 64'd0);
        check("reset_cpu_rdata", {48'd0, cpu_rdata}, 64'd0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Cold miss: clean fill of line 4.
        access(16'h0010, 1'b0, 1'b1, 16'h0000, "t1_load");
        check("t1_lit_rdata", {48'd0, last_rdata}, 64'h0000_0000_0000_BEEF);
        if (ev_q.size() == 1) check("t1_lit_fill_addr", {50'd0, ev_q[0].addr}, 64'h0004);

        // Store hit then load hit, neither touching memory.
        access(16'h0011, 1'b1, 1'b0, 16'h1234, "t2_store");
        access(16'h0011, 1'b0, 1'b1, 16'h0000, "t2_load");
        check("t2_lit_rdata", {48'd0, last_rdata}, 64'h0000_0000_0000_1234);

        // Dirty conflict miss: writeback then fill.
        access(16'h0050, 1'b0, 1'b1, 16'h0000, "t3_load");
        check("t3_lit_ops", 64'(ev_q.size()), 64'd2);
        if (ev_q.size() == 2) begin
            check("t3_lit_wb_first", {63'd0, ev_q[0].wr}, 64'd1);
            check("t3_lit_wb_addr", {50'd0, ev_q[0].addr}, 64'h0004);
            check("t3_lit_wb_word1", {48'd0, ev_q[0].data[31:16]}, 64'h1234);
            check("t3_lit_fill_addr", {50'd0, ev_q[1].addr}, 64'h0014);
        end
`ifdef DCACHE_STATS_EN
        check("stats_hit_cnt", {48'd0, hit_cnt}, 64'd2);
        check("stats_miss_cnt", {48'd0, miss_cnt}, 64'd2);
        check("stats_wb_cnt", {48'd0, wb_cnt}, 64'd1);
`endif
        idle();

        // Clean conflict miss, then eight back-to-back hits.
        access(16'h0090, 1'b0, 1'b1, 16'h0000, "t4_miss");
        check("t4_lit_no_wb", 64'(ev_q.size()), 64'd1);
        start = cyc;
        access(16'h0090, 1'b0, 1'b1, 16'h0000, "t4_h0");
        access(16'h0091, 1'b0, 1'b1, 16'h0000, "t4_h1");
        access(16'h0092, 1'b1, 1'b0, 16'hA5A5, "t4_h2");
        access(16'h0092, 1'b0, 1'b1, 16'h0000, "t4_h3");
        access(16'h0093, 1'b1, 1'b1, 16'h5A5A, "t4_h4");
        access(16'h0093, 1'b0, 1'b1, 16'h0000, "t4_h5");
        access(16'h0090, 1'b1, 1'b0, 16'h0F0F, "t4_h6");
        access(16'h0090, 1'b0, 1'b1, 16'h0000, "t4_h7");
        check("t4_burst_cycles", 64'(cyc - start), 64'd8);
        check("t4_lit_rdata", {48'd0, last_rdata}, 64'h0F0F);
        idle();

        // Reset in the middle of a fill.
        rsp_delay = 20;
        cpu_addr  = 16'h0100;
        cpu_re    = 1'b1;
        n = 0;
        while (mem_rd !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_fill_started", {63'd0, mem_rd}, 64'd1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        cpu_re = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_mem_rd_dropped", {63'd0, mem_rd}, 64'd0);
        check("t5_mem_wr_low", {63'd0, mem_wr}, 64'd0);
        check("t5_cpu_rdy_low", {63'd0, cpu_rdy}, 64'd0);
`ifdef DCACHE_STATS_EN
        check("t5_stats_cleared", {16'd0, hit_cnt, miss_cnt, wb_cnt}, 64'd0);
`endif
        model_reset();
        rsp_delay = 3;
        @(posedge clk);
        #1;
        access(16'h0090, 1'b0, 1'b1, 16'h0000, "t5_prior_hit");
        check("t5_lit_now_misses", 64'(ev_q.size()), 64'd1);
        access(16'h0100, 1'b0, 1'b1, 16'h0000, "t5_refill");
        idle();
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
